// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         uart_tx_byte;
  logic               uart_send_request;
  logic               uart_busy;
  logic               uart_byte_available;
  logic [ID_W-1:0]    grant_id;
  logic               active;

  modport master (
    input  req, req_data, uart_busy, uart_byte_available,
    output ack, uart_tx_byte, uart_send_request, grant_id, active
  );

  modport slave (
    output req, req_data, uart_busy, uart_byte_available,
    input  ack, uart_tx_byte, uart_send_request, grant_id, active
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one half-duplex UART transmitter
// Retries transparently when an RX frame steals the UART's shared busy period.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int TIMEOUT_CLKS = 2048,
  parameter int ID_W         = $clog2(N_REQ)
) (
  input logic               clk,
  input logic               rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rx_seen_q, rx_seen_d;
  logic               busy_q, avail_q;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               send_q, send_d;
  logic [7:0]         byte_q, byte_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic               active_q, active_d;

  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    idx;

  // Scan from farthest to nearest so the requester closest to the pointer wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int d = N_REQ - 1; d >= 0; d--) begin
      idx = ID_W'((int'(ptr_q) + d) % N_REQ);
      if (bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rx_seen_d = rx_seen_q;
    ack_d     = '0;
    send_d    = send_q;
    byte_d    = byte_q;
    gid_d     = gid_q;
    active_d  = active_q;
    unique case (state_q)
      IDLE: begin
        if (found && !busy_q) begin
          byte_d   = bus.req_data[{winner, 3'b000} +: 8];
          gid_d    = winner;
          active_d = 1'b1;
          send_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (busy_q) begin
          send_d    = 1'b0;
          rx_seen_d = 1'b0;
          state_d   = WAIT_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
          send_d   = 1'b0;
          active_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        rx_seen_d = rx_seen_q | avail_q;
        if (!busy_q) begin
          // A byte_available during the busy period means it was RX, not our TX.
          if (rx_seen_q || avail_q) begin
            send_d  = 1'b1;
            cnt_d   = '0;
            state_d = ISSUE;
          end else begin
            ack_d    = N_REQ'(1) << gid_q;
            ptr_d    = (gid_q == ID_W'(N_REQ - 1)) ? '0 : gid_q + ID_W'(1);
            active_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // busy_q resets high so nothing issues until the UART has been seen idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      rx_seen_q <= 1'b0;
      busy_q    <= 1'b1;
      avail_q   <= 1'b0;
      ack_q     <= '0;
      send_q    <= 1'b0;
      byte_q    <= '0;
      gid_q     <= '0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      rx_seen_q <= rx_seen_d;
      busy_q    <= bus.uart_busy;
      avail_q   <= bus.uart_byte_available;
      ack_q     <= ack_d;
      send_q    <= send_d;
      byte_q    <= byte_d;
      gid_q     <= gid_d;
      active_q  <= active_d;
    end
  end

  assign bus.ack               = ack_q;
  assign bus.uart_send_request = send_q;
  assign bus.uart_tx_byte      = byte_q;
  assign bus.grant_id          = gid_q;
  assign bus.active            = active_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and random checks of uart_tx_arbiter against a queue model
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CLKS(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [N-1:0] req;
  logic [7:0]   data [N];
  always_comb begin
    bus.req = req;
    for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = data[i];
  end

  // UART model: shared busy for RX and TX, RX has priority when both start together.
  int         bit_clks = 4;
  logic       mute = 1'b0;
  int         rx_cmd = 0;
  int         rx_served = 0;
  logic       u_busy = 1'b0;
  logic       u_avail = 1'b0;
  logic       u_is_rx = 1'b0;
  int         u_cnt = 0;
  logic [7:0] u_byte = 8'h00;
  logic [7:0] last_tx = 8'h00;
  assign bus.uart_busy           = u_busy;
  assign bus.uart_byte_available = u_avail;

  always @(posedge clk) begin
    u_avail <= 1'b0;
    if (u_busy) begin
      if (u_cnt == 1) begin
        u_busy <= 1'b0;
        if (u_is_rx) u_avail <= 1'b1;
        else last_tx <= u_byte;
      end
      u_cnt <= u_cnt - 1;
    end else if (rx_cmd != rx_served) begin
      rx_served <= rx_served + 1;
      u_busy    <= 1'b1;
      u_is_rx   <= 1'b1;
      u_cnt     <= 10 * bit_clks;
    end else if (bus.uart_send_request && !mute) begin
      u_busy  <= 1'b1;
      u_is_rx <= 1'b0;
      u_byte  <= bus.uart_tx_byte;
      u_cnt   <= 10 * bit_clks;
    end
  end

  int         checks = 0;
  int         errors = 0;
  int         ptr_m, cur_gid, grant_cnt, ack_cnt, tmo_cnt, issue_cnt;
  logic [7:0] cur_data;
  logic       act_prev, send_prev, auto_drop;
  int         grant_log [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(int p, logic [N-1:0] m);
    for (int d = 0; d < N; d++) if (m[(p + d) % N]) return (p + d) % N;
    return -1;
  endfunction

  // One clock: observe after the edge, update the reference model, then let requesters react.
  task automatic step();
    int w;
    @(posedge clk);
    #1;
    if (bus.active && !act_prev) begin
      w = rr_pick(ptr_m, req);
      chk("grant_id", bus.grant_id, w);
      chk("grant_byte", bus.uart_tx_byte, data[(w < 0) ? 0 : w]);
      chk("grant_send", bus.uart_send_request, 1);
      cur_gid  = w;
      cur_data = data[(w < 0) ? 0 : w];
      grant_cnt++;
      grant_log.push_back(w);
    end else if (bus.active) begin
      chk("byte_stable", bus.uart_tx_byte, cur_data);
    end
    if (bus.uart_send_request && !send_prev) issue_cnt++;
    if (bus.ack != '0) begin
      chk("ack_after_grant", act_prev, 1);
      chk("ack_onehot", bus.ack, 32'(1) << cur_gid);
      chk("ack_inactive", bus.active, 0);
      chk("ack_byte_sent", last_tx, cur_data);
      ptr_m = (cur_gid + 1) % N;
      ack_cnt++;
      if (auto_drop) req = req & ~bus.ack;
    end else if (!bus.active && act_prev) begin
      tmo_cnt++;
    end
    act_prev  = bus.active;
    send_prev = bus.uart_send_request;
  endtask

  task automatic wait_acks(int target, int budget, string tag);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, ack_cnt >= target, 1);
  endtask

  task automatic model_reset();
    ptr_m     = 0;
    act_prev  = 1'b0;
    send_prev = 1'b0;
  endtask

  initial begin
    int n, gb, a0, g0, i0, t0, issued;
    logic seen;
    int exp_rr [5] = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req = '0;
    auto_drop = 1'b1;
    for (int i = 0; i < N; i++) data[i] = 8'h00;
    grant_cnt = 0; ack_cnt = 0; tmo_cnt = 0; issue_cnt = 0; cur_gid = 0; cur_data = 8'h00;
    model_reset();
    #1;
    chk("rst_ack", bus.ack, 0);
    chk("rst_send", bus.uart_send_request, 0);
    chk("rst_byte", bus.uart_tx_byte, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_active", bus.active, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) step();

    // Round robin with wrap: all four held, grants 0,1,2,3,0.
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) data[i] = 8'hA0 + 8'(i);
    gb = grant_log.size();
    a0 = ack_cnt;
    req = 4'hF;
    wait_acks(a0 + 5, 600, "rr_acks");
    req = '0;
    auto_drop = 1'b1;
    for (int k = 0; k < 5; k++)
      chk("rr_order", (gb + k < grant_log.size()) ? grant_log[gb + k] : -1, exp_rr[k]);
    repeat (3) step();

    // Single byte with idle UART: grant one edge after req.
    data[0] = 8'h55;
    req = 4'b0001;
    a0 = ack_cnt;
    step();
    chk("latency_grant", bus.active, 1);
    n = 0;
    while (bus.uart_send_request && n < 10) begin
      n++;
      step();
    end
    chk("send_until_busy", (n >= 1 && n <= 4), 1);
    chk("uart_busy_at_drop", u_busy, 1);
    wait_acks(a0 + 1, 200, "single_ack");
    chk("single_sent", last_tx, 8'h55);

    // Sparse wrap: serve 2 (pointer -> 3), then 1001 must grant 3 before 0.
    data[2] = 8'h5A;
    req = 4'b0100;
    wait_acks(ack_cnt + 1, 200, "sparse_pre_ack");
    data[3] = 8'h33;
    data[0] = 8'h30;
    gb = grant_log.size();
    a0 = ack_cnt;
    req = 4'b1001;
    wait_acks(a0 + 2, 400, "sparse_acks");
    chk("sparse_first", (gb < grant_log.size()) ? grant_log[gb] : -1, 3);
    chk("sparse_second", (gb + 1 < grant_log.size()) ? grant_log[gb + 1] : -1, 0);

    // RX collision: RX frame starts on the edge send_request rises.
    repeat (2) step();
    data[1] = 8'h12;
    a0 = ack_cnt; g0 = grant_cnt; i0 = issue_cnt;
    req = 4'b0010;
    rx_cmd++;
    wait_acks(a0 + 1, 400, "rx_ack");
    chk("rx_single_grant", grant_cnt - g0, 1);
    chk("rx_reissued", issue_cnt - i0, 2);
    chk("rx_frame_taken", rx_served, rx_cmd);
    chk("rx_then_sent", last_tx, 8'h12);

    // Timeout: UART ignores the request for exactly TMO cycles.
    repeat (2) step();
    mute = 1'b1;
    data[2] = 8'h44;
    a0 = ack_cnt; g0 = grant_cnt; t0 = tmo_cnt;
    req = 4'b0100;
    step();
    n = 0;
    while (bus.uart_send_request && n < 40) begin
      n++;
      step();
    end
    chk("tmo_send_cycles", n, TMO);
    chk("tmo_inactive", bus.active, 0);
    chk("tmo_no_ack", ack_cnt - a0, 0);
    chk("tmo_counted", tmo_cnt - t0, 1);
    mute = 1'b0;
    step();
    chk("tmo_regrant", grant_cnt - g0, 2);
    chk("tmo_regrant_id", grant_log[grant_log.size() - 1], 2);
    wait_acks(a0 + 1, 200, "tmo_final_ack");

    // Reset 500 clocks into a long frame, then a fresh byte after the UART drains.
    repeat (2) step();
    bit_clks = 100;
    data[3] = 8'h77;
    req = 4'b1000;
    n = 0;
    while (!(u_busy && !u_is_rx) && n < 50) begin
      n++;
      step();
    end
    repeat (500) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_send", bus.uart_send_request, 0);
    chk("rstmid_ack", bus.ack, 0);
    chk("rstmid_active", bus.active, 0);
    req = '0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    data[1] = 8'h11;
    req = 4'b0010;
    a0 = ack_cnt;
    seen = 1'b0;
    n = 0;
    while (u_busy && n < 1200) begin
      n++;
      step();
      if (bus.active) seen = 1'b1;
    end
    chk("rstmid_no_grant_busy", seen, 0);
    bit_clks = 4;
    wait_acks(a0 + 1, 300, "rstmid_new_ack");
    chk("rstmid_new_id", grant_log[grant_log.size() - 1], 1);

    // Random traffic with occasional RX frames.
    bit_clks = 2;
    a0 = ack_cnt;
    issued = 0;
    for (int s = 0; s < 1500; s++) begin
      step();
      if ($urandom_range(0, 5) == 0) begin
        int i;
        i = $urandom_range(0, N - 1);
        if (!req[i]) begin
          data[i] = 8'($urandom);
          req[i] = 1'b1;
          issued++;
        end
      end
      if ($urandom_range(0, 99) == 0) rx_cmd++;
    end
    n = 0;
    while ((req != '0 || bus.active) && n < 3000) begin
      n++;
      step();
    end
    chk("rand_drained", (req == '0 && !bus.active), 1);
    chk("rand_acks", ack_cnt - a0, issued);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
